// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
//   - FSM state encoding (IDLE/EXEC/RESP)
//   - highest legal ALU opcode and a few named opcodes
//   - bit positions inside the 7-bit ALU flag vector
package alu_sched_pkg;

   localparam int FLAGW = 7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [5:0] OP_ADD = 6'd0;
   localparam logic [5:0] OP_SUB = 6'd1;
   localparam logic [5:0] OP_MUL = 6'd2;
   localparam logic [5:0] OP_DIV = 6'd3;
   localparam logic [5:0] OP_GE  = 6'd34;
   localparam logic [5:0] OP_MAX = 6'd34;

   localparam int FLG_CARRY    = 0;
   localparam int FLG_OVERFLOW = 1;
   localparam int FLG_ZERO     = 2;
   localparam int FLG_NEGATIVE = 3;
   localparam int FLG_PARITY   = 4;
   localparam int FLG_MODULO   = 5;
   localparam int FLG_SIGN     = 6;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle of the ALU scheduler.
//   req_valid/req_ready : per-requester handshake (ready is a one-hot grant)
//   req_a/req_b/req_sel : packed operands/opcodes, requester i at [i*W +: W]
//   rsp_*               : single response channel, valid held until rsp_ready
// master = requester/consumer side, slave = scheduler side.
interface alu_rr_scheduler_if #(
   parameter int N    = 64,
   parameter int NREQ = 4,
   parameter int SELW = 6,
   parameter int IDW  = 2
) ();
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*N-1:0]    req_a;
   logic [NREQ*N-1:0]    req_b;
   logic [NREQ*SELW-1:0] req_sel;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [N-1:0]         rsp_result;
   logic [N-1:0]         rsp_upper;
   logic [6:0]           rsp_flags;
   logic                 rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_upper, rsp_flags, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_upper, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_rr_scheduler_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index of the highest-priority requester this cycle
//   en      : grant enable (no grant when low)
//   gnt     : one-hot grant of the first set req at or after ptr, wrapping
//   gnt_idx : binary index of gnt (0 when no grant)
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   int         pos;
   logic [IDW-1:0] idx;
   logic       found;

   // Scan NREQ positions starting at ptr; wrap at NREQ (not 2**IDW) so
   // non-power-of-two requester counts rotate correctly.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      pos     = 0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         idx = IDW'(pos);
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one external combinational ALU among NREQ
// requesters with round-robin arbitration.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : per-requester valid/ready + operands, response channel
//   alu_a/b/sel   : operands to the shared ALU (always the operand regs)
//   alu_result/upper/flags : ALU outputs, captured during EXEC
// Sequence per op: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold).
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int N    = 64,
   parameter int NREQ = 4,
   parameter int SELW = 6,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   alu_rr_scheduler_if.slave bus,
   output logic [N-1:0]      alu_a,
   output logic [N-1:0]      alu_b,
   output logic [SELW-1:0]   alu_sel,
   input  logic [N-1:0]      alu_result,
   input  logic [N-1:0]      alu_upper,
   input  logic [FLAGW-1:0]  alu_flags
);

   logic [1:0]       state_reg;
   logic [IDW-1:0]   ptr_reg;
   logic [IDW-1:0]   id_reg;
   logic [N-1:0]     op_a_reg;
   logic [N-1:0]     op_b_reg;
   logic [SELW-1:0]  op_sel_reg;
   logic [N-1:0]     rsp_result_reg;
   logic [N-1:0]     rsp_upper_reg;
   logic [FLAGW-1:0] rsp_flags_reg;
   logic             rsp_err_reg;

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_idx;
   logic             xfer;
   logic [IDW-1:0]   ptr_next;

   // Unpacked views of the packed requester buses.
   logic [N-1:0]     a_arr   [NREQ];
   logic [N-1:0]     b_arr   [NREQ];
   logic [SELW-1:0]  sel_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi]   = bus.req_a[gi*N +: N];
         assign b_arr[gi]   = bus.req_b[gi*N +: N];
         assign sel_arr[gi] = bus.req_sel[gi*SELW +: SELW];
      end
   endgenerate

   // Grants only in IDLE and never while reset is asserted.
   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req     (bus.req_valid),
      .ptr     (ptr_reg),
      .en      ((state_reg == ST_IDLE) && !rst),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Arbiter only grants valid requesters, so any grant is a transfer.
   assign xfer          = |gnt;
   assign ptr_next      = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
   assign bus.req_ready = gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         ptr_reg        <= '0;
         id_reg         <= '0;
         op_a_reg       <= '0;
         op_b_reg       <= '0;
         op_sel_reg     <= '0;
         rsp_result_reg <= '0;
         rsp_upper_reg  <= '0;
         rsp_flags_reg  <= '0;
         rsp_err_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (xfer) begin
                  op_a_reg   <= a_arr[gnt_idx];
                  op_b_reg   <= b_arr[gnt_idx];
                  op_sel_reg <= sel_arr[gnt_idx];
                  id_reg     <= gnt_idx;
                  ptr_reg    <= ptr_next;
                  state_reg  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_result_reg <= alu_result;
               rsp_upper_reg  <= alu_upper;
               rsp_flags_reg  <= alu_flags;
               rsp_err_reg    <= (int'(op_sel_reg) > int'(OP_MAX));
               state_reg      <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // ALU inputs come only from the operand regs so they never follow
   // requester inputs while an op is in flight.
   assign alu_a   = op_a_reg;
   assign alu_b   = op_b_reg;
   assign alu_sel = op_sel_reg;

   assign bus.rsp_valid  = (state_reg == ST_RESP);
   assign bus.rsp_id     = id_reg;
   assign bus.rsp_result = rsp_result_reg;
   assign bus.rsp_upper  = rsp_upper_reg;
   assign bus.rsp_flags  = rsp_flags_reg;
   assign bus.rsp_err    = rsp_err_reg;

endmodule
